usb_tx_packet: RTL

- Byte-level USB transmit packet sequencer; the transmit counterpart of the receive-side data register and PID decoder.
- Accepts a packet-type code from the protocol controller and emits a byte sequence to the downstream bit serializer: SYNC, PID, payload, CRC16, EOP request.
- Payload bytes are pulled from the TX FIFO.
- Sits between the protocol FSM / TX FIFO and the NRZI/bit-stuff serializer.

---
 rtl/usb_pkg.sv | 51 +++++
 rtl/usb_crc16.sv | 22 ++
 rtl/usb_tx_packet.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions: packet codes, PID nibbles, SYNC byte and the CRC16
// constants with a byte-wide update helper.
package usb_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'b000,
        PKT_IN    = 3'b010,
        PKT_ACK   = 3'b011,
        PKT_DATA0 = 3'b100,
        PKT_DATA1 = 3'b101,
        PKT_NAK   = 3'b110
    } usb_packet_e;

    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY = 16'h8005;

    // Bit-reversed polynomial; data and CRC are both shifted LSB first.
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

    function automatic logic [7:0] pid_byte(input usb_packet_e code);
        logic [3:0] pid;
        case (code)
            PKT_IN:    pid = PID_IN;
            PKT_ACK:   pid = PID_ACK;
            PKT_DATA0: pid = PID_DATA0;
            PKT_DATA1: pid = PID_DATA1;
            PKT_NAK:   pid = PID_NAK;
            default:   pid = 4'b0000;
        endcase
        return {~pid, pid};
    endfunction

    function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY_REFL;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 register: one payload byte folded in per update cycle.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        update,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;

    always_ff @(posedge clk) begin
        if (!n_rst || clear) crc_q <= CRC16_INIT;
        else if (update)     crc_q <= crc16_next(crc_q, data_in);
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/usb_tx_packet.sv
// USB transmit packet sequencer: SYNC, PID, payload, CRC16, EOP request.
// Define TX_NAK_EN to accept code 110 as a NAK handshake.
module usb_tx_packet
    import usb_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [2:0]       tx_packet,
    input  logic             tx_start,
    input  logic [CNT_W-1:0] buffer_occupancy,
    input  logic [7:0]       tx_packet_data,
    output logic             get_tx_packet_data,
    output logic [7:0]       tx_byte,
    output logic             tx_byte_valid,
    input  logic             byte_done,
    output logic             tx_eop,
    input  logic             eop_done,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_error,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SYNC   = 4'd1,
        ST_PID    = 4'd2,
        ST_FETCH  = 4'd3,
        ST_LOAD   = 4'd4,
        ST_DATA   = 4'd5,
        ST_CRC_LO = 4'd6,
        ST_CRC_HI = 4'd7,
        ST_EOP    = 4'd8,
        ST_DONE   = 4'd9
    } tx_state_e;

    tx_state_e        state, state_next;
    usb_packet_e      code_q;
    usb_packet_e      start_code;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       byte_q;
    logic             byte_gap_q;
    logic             error_q;
    logic             crc_clear, crc_update;
    logic [15:0]      crc;
    logic             code_ok, start_ok, is_data_start, is_data_q;
    logic             byte_state, bd_ok;

    assign start_code    = usb_packet_e'(tx_packet);
    assign is_data_start = (start_code == PKT_DATA0) || (start_code == PKT_DATA1);
    assign is_data_q     = (code_q == PKT_DATA0) || (code_q == PKT_DATA1);

    always_comb begin
        code_ok = 1'b0;
        case (start_code)
            PKT_IN, PKT_ACK, PKT_DATA0, PKT_DATA1: code_ok = 1'b1;
`ifdef TX_NAK_EN
            PKT_NAK: code_ok = 1'b1;
`else
            PKT_NAK: code_ok = 1'b0;
`endif
            default: code_ok = 1'b0;
        endcase
    end

    assign start_ok = code_ok &&
                      (!is_data_start || (buffer_occupancy <= CNT_W'(MAX_BYTES)));

    // Serializer handshake: tx_byte is offered while tx_byte_valid=1 and held
    // unchanged until byte_done; the cycle after byte_done valid is always low,
    // and byte_done seen while valid is low is ignored.
    assign byte_state = (state == ST_SYNC) || (state == ST_PID) || (state == ST_DATA) ||
                        (state == ST_CRC_LO) || (state == ST_CRC_HI);
    assign bd_ok      = byte_done && byte_state && !byte_gap_q;

    always_ff @(posedge clk) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next         = state;
        get_tx_packet_data = 1'b0;
        crc_clear          = 1'b0;
        crc_update         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_start && start_ok) begin
                    state_next = ST_SYNC;
                    crc_clear  = 1'b1;
                end
            end
            ST_SYNC:   if (bd_ok) state_next = ST_PID;
            ST_PID: begin
                if (bd_ok) begin
                    if (is_data_q) state_next = (count_q != '0) ? ST_FETCH : ST_CRC_LO;
                    else           state_next = ST_EOP;
                end
            end
            ST_FETCH: begin
                get_tx_packet_data = 1'b1;
                state_next         = ST_LOAD;
            end
            ST_LOAD: begin
                crc_update = 1'b1;
                state_next = ST_DATA;
            end
            ST_DATA:   if (bd_ok) state_next = (count_q != '0) ? ST_FETCH : ST_CRC_LO;
            ST_CRC_LO: if (bd_ok) state_next = ST_CRC_HI;
            ST_CRC_HI: if (bd_ok) state_next = ST_EOP;
            ST_EOP:    if (eop_done) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Byte register is loaded on the transition into each byte state, so the
    // value is already in place when valid rises.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            code_q     <= PKT_NONE;
            count_q    <= '0;
            byte_q     <= '0;
            byte_gap_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            error_q    <= tx_start && (state == ST_IDLE) && !start_ok;
            byte_gap_q <= bd_ok;
            case (state)
                ST_IDLE: begin
                    if (tx_start && start_ok) begin
                        code_q  <= start_code;
                        count_q <= is_data_start ? buffer_occupancy : '0;
                        byte_q  <= SYNC_BYTE;
                    end
                end
                ST_SYNC: if (bd_ok) byte_q <= pid_byte(code_q);
                ST_PID, ST_DATA: begin
                    if (bd_ok && state_next == ST_CRC_LO) byte_q <= ~crc[7:0];
                end
                ST_LOAD: begin
                    byte_q  <= tx_packet_data;
                    count_q <= count_q - CNT_W'(1);
                end
                ST_CRC_LO: if (bd_ok) byte_q <= ~crc[15:8];
                default: ;
            endcase
        end
    end

    usb_crc16 u_crc16 (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (crc_clear),
        .update  (crc_update),
        .data_in (tx_packet_data),
        .crc_out (crc)
    );

    assign tx_byte_valid = byte_state && !byte_gap_q;
    assign tx_byte       = tx_byte_valid ? byte_q : 8'h00;
    assign tx_eop        = (state == ST_EOP);
    assign tx_busy       = (state != ST_IDLE);
    assign tx_done       = (state == ST_DONE);
    assign tx_error      = error_q;
    assign state_dbg     = state;

endmodule
